// File: rtl/reg3_cmd_sched.sv
// Round-robin command scheduler for one shared inc/load/clear register.
// Drives the register controls one-hot and tracks its value in a shadow.
module reg3_cmd_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             reg_inc,
  output logic             reg_write_en,
  output logic             reg_reset,
  output logic [WIDTH-1:0] reg_datain,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] done_value,
  output logic [WIDTH-1:0] cur_value,
  output logic             busy
);

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_INCN = 2'b11;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_EXEC} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] shadow_q, shadow_nxt;
  logic             gnt;
  logic             accept;
  logic             exec_last;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] data_sel;

  assign op_sel    = gnt ? req1_op : req0_op;
  assign data_sel  = gnt ? req1_data : req0_data;
  assign cur_value = shadow_q;
  assign busy      = (state != ST_IDLE);

  // Next-state, arbitration and one-hot register control decode
  always_comb begin
    state_nxt    = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    gnt          = 1'b0;
    accept       = 1'b0;
    reg_inc      = 1'b0;
    reg_write_en = 1'b0;
    reg_reset    = 1'b0;
    reg_datain   = '0;
    shadow_nxt   = shadow_q;
    cnt_nxt      = cnt_q;
    exec_last    = 1'b0;
    case (state)
      ST_INIT: begin
        // Clear pulse only once reset is released, never while it is held
        reg_reset  = reset;
        shadow_nxt = '0;
        state_nxt  = ST_IDLE;
      end
      ST_IDLE: begin
        gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~gnt;
          req1_ready = gnt;
          cnt_nxt    = data_sel[CNT_W-1:0];
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_CLR: begin
            reg_reset  = 1'b1;
            shadow_nxt = '0;
            exec_last  = 1'b1;
          end
          OP_INC: begin
            reg_inc    = 1'b1;
            shadow_nxt = shadow_q + WIDTH'(1);
            exec_last  = 1'b1;
          end
          OP_LOAD: begin
            reg_write_en = 1'b1;
            reg_datain   = data_q;
            shadow_nxt   = data_q;
            exec_last    = 1'b1;
          end
          OP_INCN: begin
            if (cnt_q == '0) begin
              exec_last = 1'b1;
            end else begin
              reg_inc    = 1'b1;
              shadow_nxt = shadow_q + WIDTH'(1);
              cnt_nxt    = cnt_q - CNT_W'(1);
              exec_last  = (cnt_q == CNT_W'(1));
            end
          end
          default: exec_last = 1'b1;
        endcase
        if (exec_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, shadow, command latch and completion registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_INIT;
      shadow_q   <= '0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      op_q       <= OP_CLR;
      data_q     <= '0;
      id_q       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      done_value <= '0;
    end else begin
      state    <= state_nxt;
      shadow_q <= shadow_nxt;
      cnt_q    <= cnt_nxt;
      done     <= (state == ST_EXEC) && exec_last;
      if ((state == ST_EXEC) && exec_last) begin
        done_id    <= id_q;
        done_value <= shadow_nxt;
      end
      if (accept) begin
        op_q   <= op_sel;
        data_q <= data_sel;
        id_q   <= gnt;
        last_q <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_reg3_cmd_sched.sv
// Bench for reg3_cmd_sched: command table plus reset/burst corner sequences,
// with completions checked against a queue of expected results.
module tb_reg3_cmd_sched;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_INCN = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic        reg_inc, reg_write_en, reg_reset;
  logic [15:0] reg_datain;
  logic        done, done_id;
  logic [15:0] done_value, cur_value;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        id;
    logic [15:0] val;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        v0;
    logic [1:0]  op0;
    logic [15:0] d0;
    logic        v1;
    logic [1:0]  op1;
    logic [15:0] d1;
    logic        eid;
    logic [15:0] eval;
    int          lat;
  } vec_t;
  vec_t tbl[8];

  reg3_cmd_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .reg_inc(reg_inc), .reg_write_en(reg_write_en), .reg_reset(reg_reset), .reg_datain(reg_datain),
    .done(done), .done_id(done_id), .done_value(done_value), .cur_value(cur_value), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request pair, wait for the handshake, then queue the expected completion
  task automatic issue(input logic v0, input logic [1:0] op0, input logic [15:0] d0,
                       input logic v1, input logic [1:0] op1, input logic [15:0] d1,
                       input logic eid, input logic [15:0] eval, input int lat, input bit push);
    logic acc = 1'b0;
    logic got = 1'b0;
    int   ac  = 0;
    req0_valid = v0; req0_op = op0; req0_data = d0;
    req1_valid = v1; req1_op = op1; req1_data = d1;
    for (int k = 0; k < 40 && !acc; k++) begin
      #2;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc = 1'b1;
        got = req1_ready;
        ac  = cyc;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      chk("grant_id", 32'(got), 32'(eid));
      if (push) sbq.push_back('{eid, eval, ac + lat});
    end
  endtask

  // Completion scoreboard and one-hot control check, sampled mid low phase
  always @(negedge clk) begin
    exp_t e;
    #2;
    chk("ctrl_onehot", 32'((32'(reg_inc) + 32'(reg_write_en) + 32'(reg_reset)) <= 1), 32'd1);
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("done_id", 32'(done_id), 32'(e.id));
        chk("done_value", 32'(done_value), 32'(e.val));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("cur_at_done", 32'(cur_value), 32'(e.val));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, OP_INC,  16'h0000, 1'b1, OP_INC,  16'h0000, 1'b0, 16'h0001, 2};
    tbl[1] = '{1'b1, OP_INC,  16'h0000, 1'b1, OP_INC,  16'h0000, 1'b1, 16'h0002, 2};
    tbl[2] = '{1'b1, OP_LOAD, 16'h1234, 1'b1, OP_LOAD, 16'h5555, 1'b0, 16'h1234, 2};
    tbl[3] = '{1'b1, OP_INC,  16'h0000, 1'b0, OP_CLR,  16'h0000, 1'b0, 16'h1235, 2};
    tbl[4] = '{1'b1, OP_INC,  16'h0000, 1'b1, OP_CLR,  16'h0000, 1'b1, 16'h0000, 2};
    tbl[5] = '{1'b1, OP_LOAD, 16'hA5A5, 1'b1, OP_LOAD, 16'h00FF, 1'b0, 16'hA5A5, 2};
    tbl[6] = '{1'b0, OP_CLR,  16'h0000, 1'b1, OP_INCN, 16'hAB03, 1'b1, 16'hA5A8, 4};
    tbl[7] = '{1'b0, OP_LOAD, 16'hFFFF, 1'b1, OP_INC,  16'h0000, 1'b1, 16'hA5A9, 2};

    // Reset held with both requesters valid: nothing may be granted
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = OP_INC; req0_data = 16'h0;
    req1_valid = 1'b1; req1_op = OP_INC; req1_data = 16'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_reg_reset", 32'(reg_reset), 32'd0);
      chk("rst_reg_inc", 32'(reg_inc), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cur", 32'(cur_value), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    #2;
    chk("init_reg_reset", 32'(reg_reset), 32'd1);
    chk("init_reg_inc", 32'(reg_inc), 32'd0);
    chk("init_reg_we", 32'(reg_write_en), 32'd0);
    chk("init_ready0", 32'(req0_ready), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cur", 32'(cur_value), 32'd0);
    chk("idle_reg_reset", 32'(reg_reset), 32'd0);
    @(negedge clk);

    foreach (tbl[i])
      issue(tbl[i].v0, tbl[i].op0, tbl[i].d0, tbl[i].v1, tbl[i].op1, tbl[i].d1,
            tbl[i].eid, tbl[i].eval, tbl[i].lat, 1'b1);

    // LOAD FFFE, then INCN 4 wrapping through zero
    issue(1'b1, OP_LOAD, 16'hFFFE, 1'b0, OP_CLR, 16'h0, 1'b0, 16'hFFFE, 2, 1'b1);
    #2;
    chk("load_we", 32'(reg_write_en), 32'd1);
    chk("load_datain", 32'(reg_datain), 32'h0000FFFE);
    chk("load_inc", 32'(reg_inc), 32'd0);
    chk("load_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    #2;
    chk("load_we_off", 32'(reg_write_en), 32'd0);
    chk("load_datain_off", 32'(reg_datain), 32'd0);
    chk("load_cur", 32'(cur_value), 32'h0000FFFE);
    @(negedge clk);
    issue(1'b1, OP_INCN, 16'h0004, 1'b0, OP_CLR, 16'h0, 1'b0, 16'h0002, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ev;
      ev = 16'hFFFE + 16'(i);
      #2;
      chk("incn_inc", 32'(reg_inc), 32'd1);
      chk("incn_cur", 32'(cur_value), 32'(ev));
      @(negedge clk);
    end
    #2;
    chk("incn_inc_off", 32'(reg_inc), 32'd0);
    chk("incn_cur_end", 32'(cur_value), 32'h00000002);
    @(negedge clk);

    // INCN with zero count is a no-op; then CLR from requester 1
    issue(1'b1, OP_INCN, 16'hFF00, 1'b0, OP_CLR, 16'h0, 1'b0, 16'h0002, 2, 1'b1);
    #2;
    chk("incn0_ctrl", 32'({reg_inc, reg_write_en, reg_reset}), 32'd0);
    chk("incn0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    issue(1'b0, OP_INC, 16'h0, 1'b1, OP_CLR, 16'h0, 1'b1, 16'h0000, 2, 1'b1);
    #2;
    chk("clr_reg_reset", 32'(reg_reset), 32'd1);
    @(negedge clk);

    // Reset during the third cycle of INCN 10 aborts it without a done
    issue(1'b1, OP_INCN, 16'h000A, 1'b0, OP_CLR, 16'h0, 1'b0, 16'h0000, 11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("abort_inc_pre", 32'(reg_inc), 32'd1);
      @(negedge clk);
    end
    reset = 1'b0;
    #2;
    chk("abort_inc_third", 32'(reg_inc), 32'd1);
    chk("abort_cur_third", 32'(cur_value), 32'h00000002);
    @(negedge clk);
    #2;
    chk("abort_inc_off", 32'(reg_inc), 32'd0);
    chk("abort_reg_reset", 32'(reg_reset), 32'd0);
    chk("abort_cur_rst", 32'(cur_value), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("reinit_reg_reset", 32'(reg_reset), 32'd1);
    chk("reinit_cur", 32'(cur_value), 32'd0);
    @(negedge clk);
    #2;
    chk("reidle_busy", 32'(busy), 32'd0);
    chk("reidle_cur", 32'(cur_value), 32'd0);
    chk("reidle_done", 32'(done), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg3_cmd_sched.md
Name: reg3_cmd_sched

Overview:
- Command scheduler that shares one 16-bit incrementable/loadable/clearable register between two requesters. Typical requesters are the core control unit and the scan/loop sequencer.
- Accepts CLR, INC, LOAD and burst-INC commands over valid/ready handshakes and arbitrates round-robin.
- Drives the register's inc / write_en / reset controls strictly one-hot.
- Keeps a shadow copy of the register value and reports completion with the resulting value.

Parameters:
- WIDTH, 16, data width of the controlled register and the shadow.
- CNT_W, 8, width of the burst-increment count, taken from req data[CNT_W-1:0].

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  2  00 CLR, 01 INC, 10 LOAD, 11 INCN.
- req0_data  input  WIDTH  LOAD value, or INCN count in the low CNT_W bits.
- req1_valid, req1_ready, req1_op, req1_data  same as requester 0, for requester 1.
- reg_inc  output  1  to register inc.
- reg_write_en  output  1  to register write_en.
- reg_reset  output  1  to register reset (active-high at the register).
- reg_datain  output  WIDTH  to register datain.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester whose command completed.
- done_value  output  WIDTH  register value after the completed command.
- cur_value  output  WIDTH  shadow of the register value.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: INIT, IDLE, EXEC.
- Reset (reset==0 at a clock edge):
  - State goes to INIT; shadow becomes 0.
  - Round-robin pointer is set so requester 0 wins the next tie.
  - done, done_id and done_value go to 0; all reg_* outputs go to 0.
  - Reset asserted mid-burst aborts the command; no done is issued for it.
- INIT (one cycle after reset is released):
  - reg_reset=1; the shadow stays 0, so the register and shadow are resynchronised.
  - Both ready outputs are 0 and busy=1.
  - Next state is IDLE.
- IDLE:
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester not granted last.
  - The granted ready is asserted combinationally in the same cycle, so the handshake completes when valid & ready are both high.
  - On acceptance: latch op, data and id, load the burst counter from data[CNT_W-1:0], and go to EXEC.
  - If no valid is high, stay in IDLE. Requester payload is ignored unless valid is high.
- EXEC (exactly one reg_* control high per cycle, never more than one):
  - CLR: one cycle with reg_reset=1; shadow becomes 0.
  - INC: one cycle with reg_inc=1; shadow becomes shadow+1 modulo 2^WIDTH (FFFF wraps to 0000).
  - LOAD: one cycle with reg_write_en=1 and reg_datain equal to the latched data; shadow becomes data.
  - INCN with N>=1: N consecutive cycles with reg_inc=1. Shadow increments each cycle with wrap. The counter decrements and EXEC exits after the cycle in which the count is 1.
  - INCN with N=0: one EXEC cycle with no control asserted; shadow unchanged.
- Completion:
  - On the cycle after the last EXEC cycle: done=1, done_id=the latched id, done_value=the updated shadow; state is IDLE.
  - A new command may be accepted in that same cycle.
- Latency: single-step commands go accept to done in 2 cycles. INCN with N>=1 takes N+1 cycles. Peak throughput is one command per 2 cycles.
- reg_datain is 0 in every cycle other than a LOAD EXEC cycle.
- cur_value always equals the shadow. Because the shadow is registered in step with the controlled register, cur_value equals the register's dataout every cycle from the cycle after INIT.
- Both ready outputs are 0 outside IDLE. The round-robin pointer updates only on acceptance.

Test Plan:
1. Reset held 3 cycles, then released -> INIT cycle with reg_reset=1 only, then IDLE; cur_value=0; no ready asserted during reset or INIT.
2. req0 LOAD 16'h1234, then req0 INC -> reg_write_en for 1 cycle with reg_datain=1234; done_value=1234 two cycles after accept; then done_value=1235; done_id=0 both times.
3. req0 and req1 valid every cycle with INC -> grants alternate 0,1,0,1 (req0 first after reset); each accept is followed 2 cycles later by done with done_value incrementing by 1.
4. LOAD 16'hFFFE, then INCN count 4 -> reg_inc high exactly 4 consecutive cycles; cur_value goes FFFF, 0000, 0001, 0002; done_value=0002 at accept+5.
5. INCN count 0, then CLR from req1 -> first command gives no reg_* activity and done with value unchanged; CLR gives reg_reset 1 cycle and done_value=0, done_id=1.
6. Reset asserted during the third cycle of INCN count 10 -> no done, reg_inc drops at the reset edge; after release an INIT clear occurs and cur_value=0. Across all tests, reg_inc+reg_write_en+reg_reset never exceeds 1.
